mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage plus MEM/WB pipeline register; sits directly upstream of wb_stage. It takes EX/MEM control and operands, performs word, halfword and byte loads and stores on an internal synchronous data memory, and registers load data, ALU result and WB control. Outputs feed wb_stage data_in, dir and mem_to_reg directly; the hazard unit drives stall and flush.

Parameters:
ADDR_W, 8, log2 of data-memory depth in 32-bit words (default 256 words = 1 KiB).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
stall  input  1  hold MEM/WB register, suppress store
flush  input  1  load bubble into MEM/WB, suppress store
mem_read  input  1  load instruction
mem_write  input  1  store instruction
mem_to_reg  input  1  WB select, passed through
reg_write  input  1  register-file write enable, passed through
size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
load_signed  input  1  1 = sign-extend sub-word loads, 0 = zero-extend
alu_result  input  32  byte address / ALU result
write_data  input  32  store data (rt)
write_reg  input  5  destination register
wb_mem_to_reg  output  1  to wb_stage mem_to_reg
wb_reg_write  output  1  to register file
wb_data_in  output  32  aligned, extended load data, to wb_stage data_in
wb_dir  output  32  registered alu_result, to wb_stage dir
wb_write_reg  output  5  registered destination register
wb_misalign  output  1  registered misaligned-access flag

Behaviour:
- Memory: 2^ADDR_W x 32-bit words with per-byte write enables, little-endian lanes (addr[1:0]=0 selects bits [7:0]). Word index = alu_result[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo memory size. Contents are not reset.
- Load latency: the load issued in cycle N appears on wb_data_in after edge N+1, together with all other wb_* outputs. The read is synchronous and captured straight into the MEM/WB register.
- Store: write_data[7:0] goes to lane addr[1:0] for a byte. write_data[15:0] goes to lanes {addr[1],0} for a half. A word writes all lanes. The write takes effect at the same edge, and a load of that address in the following cycle returns the new data.
- Sub-word load: select the lane(s) as above, then sign- or zero-extend per load_signed. Word loads ignore load_signed.
- Misaligned: half with addr[0]=1, or word/reserved size with addr[1:0]!=0, while mem_read or mem_write is high. On a misaligned access:
  - no memory write
  - wb_data_in = 0
  - wb_reg_write = 0
  - wb_misalign = 1 for that instruction's MEM/WB slot
- mem_read and mem_write both high: the store is performed, wb_data_in = 0, and the other fields pass through.
- Neither mem_read nor mem_write: no memory access, wb_data_in = 0, and wb_dir/control pass through (ALU instructions).
- stall=1: MEM/WB register holds its previous value and the store is suppressed, so the same instruction is re-presented next cycle.
- flush=1 (priority over stall): store suppressed; next cycle wb_reg_write=0, wb_mem_to_reg=0, wb_misalign=0, wb_data_in=0, wb_dir=0, wb_write_reg=0.
- Reset (rst=0 at edge, priority over stall and flush): all wb_* outputs = 0 and no memory write that cycle. Reset mid-store aborts the store.

Test Plan:
1. Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> one cycle after the load, wb_data_in=0xDEADBEEF, wb_dir=0x10, wb_mem_to_reg=1.
2. Store byte 0x5A at 0x13 over word 0x00000000, then load word at 0x10 -> 0x5A000000. Load byte at 0x13, signed -> 0x0000005A. Store byte 0x80 at 0x11, then load signed -> 0xFFFFFF80 and unsigned -> 0x00000080.
3. Store half 0x8001 at 0x22, then load half signed at 0x22 -> 0xFFFF8001 and unsigned -> 0x00008001. Load half at 0x21 -> wb_misalign=1, wb_reg_write=0, wb_data_in=0, memory unchanged.
4. Stall held 2 cycles during store word 0x1234 at 0x40, then released -> memory written once; wb_* outputs frozen while stalled. Flush with stall during store 0xFFFF at 0x44 -> word at 0x44 unchanged, next cycle wb_reg_write=0.
5. With ADDR_W=8, store word 0xCAFEF00D at 0x400, then load at 0x000 -> 0xCAFEF00D (wrap).
6. Assert rst=0 during store 0x77 at 0x50 after writing 0x11 there -> word stays 0x11 and all wb_* outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register: byte/half/word loads and
// stores on an internal synchronous data memory, feeding wb_stage directly.
module mem_stage #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [1:0]  size,
    input  logic        load_signed,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  write_reg,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_data_in,
    output logic [31:0] wb_dir,
    output logic [4:0]  wb_write_reg,
    output logic        wb_misalign
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic [31:0]       mem [DEPTH];

    size_e             sz;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              misalign;
    logic              store_en;
    logic [3:0]        be;
    logic [31:0]       wdata;

    // Registered read word plus what is needed to align/extend it after the edge
    logic [31:0]       rd_word;
    logic [1:0]        rd_lane;
    size_e             rd_size;
    logic              rd_signed;
    logic              rd_valid;

    assign sz   = size_e'(size);
    assign idx  = alu_result[ADDR_W+1:2];
    assign lane = alu_result[1:0];

    always_comb begin
        misalign = 1'b0;
        unique case (sz)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = lane[0];
            default: misalign = (lane != 2'b00);
        endcase
        misalign = misalign & (mem_read | mem_write);
    end

    assign store_en = rst & mem_write & ~misalign & ~stall & ~flush;

    always_comb begin
        be    = '0;
        wdata = '0;
        unique case (sz)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data[15:0]}};
            end
            default: begin
                be    = '1;
                wdata = write_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && !stall) begin
            rd_word   <= mem[idx];
            rd_lane   <= lane;
            rd_size   <= sz;
            rd_signed <= load_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_dir        <= '0;
            wb_write_reg  <= '0;
            wb_misalign   <= 1'b0;
            rd_valid      <= 1'b0;
        end else if (!stall) begin
            wb_mem_to_reg <= mem_to_reg;
            wb_reg_write  <= reg_write & ~misalign;
            wb_dir        <= alu_result;
            wb_write_reg  <= write_reg;
            wb_misalign   <= misalign;
            // read+write together returns zero load data; the store still happens
            rd_valid      <= mem_read & ~mem_write & ~misalign;
        end
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = '0;
        unique case (rd_lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
        endcase
        rd_half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];

        wb_data_in = '0;
        if (rd_valid) begin
            unique case (rd_size)
                SZ_BYTE: wb_data_in = {{24{rd_signed & rd_byte[7]}}, rd_byte};
                SZ_HALF: wb_data_in = {{16{rd_signed & rd_half[15]}}, rd_half};
                default: wb_data_in = rd_word;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table of one-cycle instructions with
// explicit expected MEM/WB contents, routed through a scoreboard queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0]  size;
    logic        load_signed;
    logic [31:0] alu_result, write_data;
    logic [4:0]  write_reg;
    logic        wb_mem_to_reg, wb_reg_write, wb_misalign;
    logic [31:0] wb_data_in, wb_dir;
    logic [4:0]  wb_write_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .size         (size),
        .load_signed  (load_signed),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .write_reg    (write_reg),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write (wb_reg_write),
        .wb_data_in   (wb_data_in),
        .wb_dir       (wb_dir),
        .wb_write_reg (wb_write_reg),
        .wb_misalign  (wb_misalign)
    );

    typedef struct {
        string       name;
        logic        rst, stall, flush, rd, wr, m2r, rw;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr, wd;
        logic [4:0]  wreg;
        logic        x_m2r, x_rw, x_mis;
        logic [31:0] x_data, x_dir;
        logic [4:0]  x_wreg;
    } vec_t;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(string nm, logic rd, logic wr, logic m2r, logic rw,
                                logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd,
                                logic [4:0] wreg, logic [31:0] xd, logic xm);
        vec_t v;
        v.name = nm; v.rst = 1'b1; v.stall = 1'b0; v.flush = 1'b0;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.sz = sz; v.sg = sg;
        v.addr = a; v.wd = wd; v.wreg = wreg;
        v.x_m2r = m2r; v.x_rw = rw & ~xm; v.x_mis = xm;
        v.x_data = xd; v.x_dir = a; v.x_wreg = wreg;
        return v;
    endfunction

    function automatic vec_t st(string nm, logic [1:0] sz, logic [31:0] a, logic [31:0] d, logic xm);
        return mk(nm, 1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, a, d, 5'd0, 32'h0, xm);
    endfunction

    function automatic vec_t ld(string nm, logic [1:0] sz, logic sg, logic [31:0] a,
                                logic [4:0] wreg, logic [31:0] xd, logic xm);
        return mk(nm, 1'b1, 1'b0, 1'b1, 1'b1, sz, sg, a, 32'h0, wreg, xd, xm);
    endfunction

    function automatic vec_t zero_exp(vec_t v);
        v.x_m2r = 1'b0; v.x_rw = 1'b0; v.x_mis = 1'b0;
        v.x_data = '0; v.x_dir = '0; v.x_wreg = '0;
        return v;
    endfunction

    // Stalled slot: instruction is presented but MEM/WB keeps the previous contents
    function automatic vec_t stalled(vec_t v, vec_t prev);
        v.stall = 1'b1;
        v.x_m2r = prev.x_m2r; v.x_rw = prev.x_rw; v.x_mis = prev.x_mis;
        v.x_data = prev.x_data; v.x_dir = prev.x_dir; v.x_wreg = prev.x_wreg;
        return v;
    endfunction

    function automatic vec_t flushed(vec_t v);
        v = zero_exp(v);
        v.flush = 1'b1; v.stall = 1'b1;
        return v;
    endfunction

    function automatic vec_t in_reset(vec_t v);
        v = zero_exp(v);
        v.rst = 1'b0;
        return v;
    endfunction

    task automatic chk(string vn, string fld, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vn, fld, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; flush = v.flush;
        mem_read = v.rd; mem_write = v.wr; mem_to_reg = v.m2r; reg_write = v.rw;
        size = v.sz; load_signed = v.sg; alu_result = v.addr; write_data = v.wd;
        write_reg = v.wreg;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.name, "mem_to_reg", {31'b0, wb_mem_to_reg}, {31'b0, e.x_m2r});
        chk(e.name, "reg_write",  {31'b0, wb_reg_write},  {31'b0, e.x_rw});
        chk(e.name, "data_in",    wb_data_in,             e.x_data);
        chk(e.name, "dir",        wb_dir,                 e.x_dir);
        chk(e.name, "write_reg",  {27'b0, wb_write_reg},  {27'b0, e.x_wreg});
        chk(e.name, "misalign",   {31'b0, wb_misalign},   {31'b0, e.x_mis});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [7:0]  b [4];
        logic [31:0] r;

        rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_to_reg = 1'b0; reg_write = 1'b0; size = 2'b00; load_signed = 1'b0;
        alu_result = '0; write_data = '0; write_reg = '0;

        tbl.push_back(in_reset(mk("reset0", 1'b1, 1'b0, 1'b1, 1'b1, W, 1'b0, 32'h10, 32'h0, 5'd9, 32'h0, 1'b0)));
        tbl.push_back(in_reset(mk("reset1", 1'b0, 1'b0, 1'b0, 1'b1, W, 1'b0, 32'h14, 32'h0, 5'd8, 32'h0, 1'b0)));

        tbl.push_back(st("st_w_10",  W, 32'h10, 32'hDEADBEEF, 1'b0));
        tbl.push_back(ld("ld_w_10",  W, 1'b0, 32'h10, 5'd3, 32'hDEADBEEF, 1'b0));

        tbl.push_back(st("clr_10",   W, 32'h10, 32'h0, 1'b0));
        tbl.push_back(st("st_b_13",  B, 32'h13, 32'hFFFFFF5A, 1'b0));
        tbl.push_back(ld("ld_w_5a",  W, 1'b0, 32'h10, 5'd3, 32'h5A000000, 1'b0));
        tbl.push_back(ld("ld_bs_13", B, 1'b1, 32'h13, 5'd4, 32'h0000005A, 1'b0));
        tbl.push_back(st("st_b_11",  B, 32'h11, 32'h00000080, 1'b0));
        tbl.push_back(ld("ld_bs_11", B, 1'b1, 32'h11, 5'd5, 32'hFFFFFF80, 1'b0));
        tbl.push_back(ld("ld_bu_11", B, 1'b0, 32'h11, 5'd6, 32'h00000080, 1'b0));
        tbl.push_back(ld("ld_w_10b", W, 1'b1, 32'h10, 5'd7, 32'h5A008000, 1'b0));

        tbl.push_back(st("clr_20",   W, 32'h20, 32'h0, 1'b0));
        tbl.push_back(st("st_h_22",  H, 32'h22, 32'h12348001, 1'b0));
        tbl.push_back(ld("ld_hs_22", H, 1'b1, 32'h22, 5'd8, 32'hFFFF8001, 1'b0));
        tbl.push_back(ld("ld_hu_22", H, 1'b0, 32'h22, 5'd9, 32'h00008001, 1'b0));
        tbl.push_back(ld("ld_h_21",  H, 1'b1, 32'h21, 5'd10, 32'h0, 1'b1));
        tbl.push_back(st("st_h_21",  H, 32'h21, 32'h0000FFFF, 1'b1));
        tbl.push_back(st("st_w_22",  W, 32'h22, 32'hFFFFFFFF, 1'b1));
        tbl.push_back(ld("ld_w_20",  W, 1'b0, 32'h20, 5'd11, 32'h80010000, 1'b0));
        tbl.push_back(ld("ld_w_22",  W, 1'b0, 32'h22, 5'd12, 32'h0, 1'b1));

        tbl.push_back(mk("alu_op",   1'b0, 1'b0, 1'b0, 1'b1, W, 1'b0, 32'h12345678, 32'h0, 5'd7, 32'h0, 1'b0));
        tbl.push_back(mk("alu_odd",  1'b0, 1'b0, 1'b0, 1'b1, W, 1'b0, 32'h00000003, 32'h0, 5'd2, 32'h0, 1'b0));
        tbl.push_back(mk("rd_wr_30", 1'b1, 1'b1, 1'b1, 1'b1, W, 1'b0, 32'h30, 32'hA5A5A5A5, 5'd13, 32'h0, 1'b0));
        tbl.push_back(ld("ld_r_30",  R, 1'b1, 32'h30, 5'd14, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(ld("ld_r_32",  R, 1'b0, 32'h32, 5'd15, 32'h0, 1'b1));

        tbl.push_back(st("clr_40",   W, 32'h40, 32'h0, 1'b0));
        tbl.push_back(ld("pre_stall", W, 1'b0, 32'h10, 5'd3, 32'h5A008000, 1'b0));
        v = st("stall_40a", W, 32'h40, 32'h1234, 1'b0);
        tbl.push_back(stalled(v, tbl[$]));
        v.name = "stall_40b";
        tbl.push_back(stalled(v, tbl[$]));
        tbl.push_back(st("rel_40",   W, 32'h40, 32'h1234, 1'b0));
        tbl.push_back(ld("ld_w_40",  W, 1'b0, 32'h40, 5'd16, 32'h00001234, 1'b0));

        tbl.push_back(st("st_w_48",  W, 32'h48, 32'h600D, 1'b0));
        tbl.push_back(stalled(st("stall_48", W, 32'h48, 32'h0BAD, 1'b0), tbl[$]));
        tbl.push_back(flushed(st("flush_48", W, 32'h48, 32'h0BAD, 1'b0)));
        tbl.push_back(ld("ld_w_48",  W, 1'b0, 32'h48, 5'd17, 32'h0000600D, 1'b0));

        tbl.push_back(st("clr_44",   W, 32'h44, 32'h0, 1'b0));
        tbl.push_back(ld("pre_flush", W, 1'b0, 32'h10, 5'd3, 32'h5A008000, 1'b0));
        tbl.push_back(flushed(st("flush_44", W, 32'h44, 32'hFFFF, 1'b0)));
        tbl.push_back(ld("ld_w_44",  W, 1'b0, 32'h44, 5'd18, 32'h0, 1'b0));

        tbl.push_back(st("st_w_400", W, 32'h400, 32'hCAFEF00D, 1'b0));
        tbl.push_back(ld("ld_w_000", W, 1'b0, 32'h000, 5'd19, 32'hCAFEF00D, 1'b0));

        tbl.push_back(st("st_w_50",  W, 32'h50, 32'h11, 1'b0));
        tbl.push_back(ld("pre_rst",  W, 1'b0, 32'h10, 5'd3, 32'h5A008000, 1'b0));
        tbl.push_back(in_reset(st("rst_st_50", W, 32'h50, 32'h77, 1'b0)));
        tbl.push_back(ld("ld_w_50",  W, 1'b0, 32'h50, 5'd20, 32'h00000011, 1'b0));

        foreach (tbl[i]) apply(tbl[i]);

        // Random byte lanes assembled into a word, read back as word, halves and byte
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            b[i] = r[7:0];
            r = $urandom();
            apply(st("rnd_st_b", B, 32'h60 + i, {r[31:8], b[i]}, 1'b0));
        end
        apply(ld("rnd_ld_w",  W, 1'b1, 32'h60, 5'd21, {b[3], b[2], b[1], b[0]}, 1'b0));
        apply(ld("rnd_ld_hu", H, 1'b0, 32'h60, 5'd22, {16'h0, b[1], b[0]}, 1'b0));
        apply(ld("rnd_ld_hs", H, 1'b1, 32'h62, 5'd23, {{16{b[3][7]}}, b[3], b[2]}, 1'b0));
        apply(ld("rnd_ld_bs", B, 1'b1, 32'h61, 5'd24, {{24{b[1][7]}}, b[1]}, 1'b0));
        apply(ld("rnd_ld_bu", B, 1'b0, 32'h62, 5'd25, {24'h0, b[2]}, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
